// File: rtl/pc_rv32i_n_vp.sv
// Program counter register for an RV32I-style core.
// Holds one N-bit value. On each rising clock edge it either resets,
// loads pc_in, or holds.
// The reset input keeps its legacy name async_reset, but it acts
// synchronously: it only takes effect on a rising clock edge.
module pc_rv32i_n_vp #(
    parameter int             N           = 32,
    parameter logic [N-1:0]   RESET_VALUE = {N{1'b0}}
) (
    input  logic             clock,
    input  logic             async_reset,
    input  logic [N-1:0]     pc_in,
    input  logic             enabler,
    output logic [N-1:0]     pc_out
);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;

    // Next-state select: load pc_in when enabled, otherwise keep the current value.
    always_comb begin
        pc_d = pc_q;
        if (enabler == 1'b1) begin
            pc_d = pc_in;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register: synchronous reset takes priority over a load on the same edge.
    always_ff @(posedge clock) begin
        if (async_reset == 1'b1) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: tb/tb_pc_rv32i_n_vp.sv
// Self-checking bench for pc_rv32i_n_vp.
// Instance u8:  N=8,  reset value 0x00.
// Instance u32: N=32, reset value 0x00001000.
module tb_pc_rv32i_n_vp;

    logic        clk;

    logic        rst8;
    logic        en8;
    logic [7:0]  din8;
    logic [7:0]  dout8;

    logic        rst32;
    logic        en32;
    logic [31:0] din32;
    logic [31:0] dout32;

    int vec_cnt;
    int err_cnt;

    pc_rv32i_n_vp #(.N(8), .RESET_VALUE(8'h00)) u8 (
        .clock       (clk),
        .async_reset (rst8),
        .pc_in       (din8),
        .enabler     (en8),
        .pc_out      (dout8)
    );

    pc_rv32i_n_vp #(.N(32), .RESET_VALUE(32'h0000_1000)) u32 (
        .clock       (clk),
        .async_reset (rst32),
        .pc_in       (din32),
        .enabler     (en32),
        .pc_out      (dout32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (act !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0]  ref8;
        logic [31:0] ref32;
        logic [7:0]  prev8;
        logic        r_rst;
        logic        r_en;
        logic [31:0] r_din;

        vec_cnt = 0;
        err_cnt = 0;
        rst8  = 1'b0; en8  = 1'b0; din8  = 8'h00;
        rst32 = 1'b0; en32 = 1'b0; din32 = 32'h0;

        // Each row is {reset, enable, pc_in, pc_out after the edge}.
        tbl[0]  = '{1'b1, 1'b1, 8'h5A, 8'h00}; // reset wins over load
        tbl[1]  = '{1'b0, 1'b1, 8'h12, 8'h12}; // load
        tbl[2]  = '{1'b0, 1'b0, 8'h34, 8'h12}; // hold
        tbl[3]  = '{1'b0, 1'b0, 8'h34, 8'h12};
        tbl[4]  = '{1'b0, 1'b0, 8'h34, 8'h12};
        tbl[5]  = '{1'b1, 1'b1, 8'hFF, 8'h00}; // reset discards a same-edge load
        tbl[6]  = '{1'b0, 1'b1, 8'hFF, 8'hFF}; // all-ones
        tbl[7]  = '{1'b0, 1'b1, 8'h00, 8'h00}; // all-zeros
        tbl[8]  = '{1'b1, 1'b0, 8'hAA, 8'h00}; // reset held high
        tbl[9]  = '{1'b1, 1'b1, 8'h77, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 8'hA5, 8'hA5}; // first edge after reset released
        tbl[11] = '{1'b0, 1'b0, 8'h00, 8'hA5};

        // Table-driven vectors on the N=8 instance. Before each edge, also
        // check that pc_out has not reacted to the new inputs yet.
        prev8 = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst8 = tbl[i].rst;
            en8  = tbl[i].en;
            din8 = tbl[i].din;
            #1;
            if (i > 0) check($sformatf("tbl%0d_pre", i), {24'h0, dout8}, {24'h0, prev8});
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d", i), {24'h0, dout8}, {24'h0, tbl[i].exp});
            prev8 = tbl[i].exp;
        end

        // Randomised run on the N=8 instance, checked against a reference model.
        ref8 = prev8;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r_rst = ($urandom_range(7, 0) == 0);
            r_en  = $urandom_range(1, 0);
            r_din = $urandom;
            rst8 = r_rst;
            en8  = r_en;
            din8 = r_din[7:0];
            #1;
            check("rand8_pre", {24'h0, dout8}, {24'h0, ref8});
            ref8 = r_rst ? 8'h00 : (r_en ? r_din[7:0] : ref8);
            @(posedge clk);
            #1;
            check("rand8", {24'h0, dout8}, {24'h0, ref8});
        end

        // N=32 instance: reset goes to 0x1000, then a word-aligned top address loads.
        @(negedge clk);
        rst32 = 1'b1; en32 = 1'b1; din32 = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("n32_reset", dout32, 32'h0000_1000);
        @(negedge clk);
        rst32 = 1'b0; en32 = 1'b1; din32 = 32'hFFFF_FFFC;
        #1;
        check("n32_load_pre", dout32, 32'h0000_1000);
        @(posedge clk);
        #1;
        check("n32_load", dout32, 32'hFFFF_FFFC);

        // Randomised run on the N=32 instance.
        ref32 = 32'hFFFF_FFFC;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            r_rst = ($urandom_range(7, 0) == 0);
            r_en  = $urandom_range(1, 0);
            r_din = $urandom;
            rst32 = r_rst;
            en32  = r_en;
            din32 = r_din;
            ref32 = r_rst ? 32'h0000_1000 : (r_en ? r_din : ref32);
            @(posedge clk);
            #1;
            check("rand32", dout32, ref32);
        end

        // Odd values must load unchanged: no alignment masking.
        @(negedge clk);
        rst32 = 1'b0; en32 = 1'b1; din32 = 32'h0000_0003;
        @(posedge clk);
        #1;
        check("n32_unaligned", dout32, 32'h0000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
